// File: rtl/first_system_pkg.sv
// Shared types and constants for the first_system self-test engine and its bench.
// The default truth table is out1 = in1 & in2, out2 = in1 | in2.
package first_system_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } bist_state_e;

  localparam int unsigned NUM_VEC = 4;

  // Bits [2v+1:2v] hold the expected {out1,out2} for input vector v = {in1,in2}.
  localparam logic [7:0] EXP_TABLE_DEFAULT = 8'hD4;

endpackage

// File: rtl/bist_dwell_timer.sv
// Dwell counter: counts enabled cycles and wraps to zero on the terminal count.
// tc_o flags the last cycle of a dwell period.
module bist_dwell_timer #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DWELL_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(DWELL_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/first_system_bist.sv
// Sweeps {in1,in2} through 00..11 into first_system, samples its outputs on the
// last dwell cycle of each vector and reports the comparison against EXP_TABLE.
module first_system_bist
  import first_system_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10,
  parameter logic [7:0]  EXP_TABLE    = EXP_TABLE_DEFAULT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out1,
  input  logic       dut_out2,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_vec,
  output logic [7:0] obs_table
);

  bist_state_e state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [1:0]  drv_q, drv_d;
  logic [2:0]  err_q, err_d;
  logic        ffv_q, ffv_d;
  logic [1:0]  ffvec_q, ffvec_d;
  logic [7:0]  obs_q, obs_d;

  logic       run;
  logic       start_acc;
  logic       tc;
  logic       sample;
  logic [1:0] resp;
  logic [1:0] exp_resp;

  assign run       = (state_q == StRun);
  assign start_acc = start && !run;
  assign sample    = run && tc;
  assign resp      = {dut_out1, dut_out2};
  assign exp_resp  = EXP_TABLE[{vec_q, 1'b0} +: 2];

  bist_dwell_timer #(
    .CNT_W       (CNT_W),
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(start_acc),
    .en_i (run),
    .tc_o (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (tc && (vec_q == 2'd3)) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = run;
    done = (state_q == StDone);
    pass = done && (err_q == 3'd0);
  end

  always_comb begin
    vec_d   = vec_q;
    drv_d   = drv_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    obs_d   = obs_q;
    if (start_acc) begin
      vec_d   = 2'd0;
      drv_d   = 2'd0;
      err_d   = 3'd0;
      ffv_d   = 1'b0;
      ffvec_d = 2'd0;
      obs_d   = 8'd0;
    end else if (sample) begin
      obs_d[{vec_q, 1'b0} +: 2] = resp;
      if (resp != exp_resp) begin
        // At most four vectors can fail, so the 3-bit count never wraps.
        err_d = err_q + 3'd1;
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q;
        end
      end
      if (vec_q == 2'd3) begin
        vec_d = 2'd0;
        drv_d = 2'd0;
      end else begin
        vec_d = vec_q + 2'd1;
        drv_d = vec_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= 2'd0;
      drv_q   <= 2'd0;
      err_q   <= 3'd0;
      ffv_q   <= 1'b0;
      ffvec_q <= 2'd0;
      obs_q   <= 8'd0;
    end else begin
      vec_q   <= vec_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      obs_q   <= obs_d;
    end
  end

  assign drv_in1        = drv_q[1];
  assign drv_in2        = drv_q[0];
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;
  assign obs_table      = obs_q;

endmodule
